sprite_pixel_arbiter: RTL and testbench
=======================================

Name: sprite_pixel_arbiter

Overview:
- Shares one sprite-index ROM read port and one 16-entry palette lookup among NUM_REQ sprite engines (player tank, enemy tanks, shell).
- Grants one requester per cycle using round-robin. Drives the ROM address, passes the returned 4-bit index to the palette, and registers the 12-bit RGB result tagged with the requester ID.
- Flags chroma-key (transparent) pixels so the frame compositor can skip them.
- Sits between the sprite engines and the ROM/palette pair, ahead of the VGA colour mapper.

Parameters:
- NUM_REQ, 4, number of requesting sprite engines (2..8).
- ADDR_W, 10, sprite ROM address width (32x32 sprite).
- KEY_INDEX, 0, palette index treated as transparent.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester read request, level.
- req_addr  in  NUM_REQ*ADDR_W  packed per-requester ROM address; slice i belongs to requester i.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the winning req.
- rom_addr  out  ADDR_W  registered address to the synchronous ROM.
- rom_index  in  4  ROM data, valid one cycle after rom_addr is presented.
- pal_index  out  4  palette index, combinational copy of rom_index.
- pal_rgb  in  12  {R,G,B} from the palette, combinational from pal_index.
- rsp_valid  out  1  result valid, single-cycle pulse.
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the result.
- rsp_rgb  out  12  registered colour.
- rsp_transparent  out  1  rsp index equalled KEY_INDEX.

Behaviour:
- Reset (async assert, sync release):
  - rom_addr=0, rsp_valid=0, rsp_id=0, rsp_rgb=0, rsp_transparent=0.
  - All pipeline valids cleared; last-grant pointer = NUM_REQ-1, so requester 0 wins first.
  - Asserting reset mid-operation drops in-flight results; none are emitted after release.
- Arbitration, cycle T:
  - Search req starting at pointer+1 modulo NUM_REQ; the first set bit wins.
  - gnt is one-hot or zero.
  - On a grant, the pointer takes the winner index at the clock edge. With no grant, the pointer holds.
- Requester contract: req_addr must be stable during the cycle req is high. On gnt the address is consumed; req may stay high for back-to-back reads.
- Pipeline, no backpressure, one result per grant, in grant order:
  - S1, edge ending T: rom_addr<=winner addr; s1_valid, s1_id captured. With no grant, s1_valid=0 and rom_addr holds its value.
  - S2, edge ending T+1: s2_valid, s2_id <= s1. The ROM returns rom_index during T+2.
  - S3, edge ending T+2: rsp_rgb<=pal_rgb, rsp_transparent<=(rom_index==KEY_INDEX), rsp_id<=s2_id, rsp_valid<=s2_valid.
- Latency: rsp_valid is high in cycle T+3 for a grant in T.
- Throughput: 1 result/cycle.
- Bubbles: cycles without a grant produce rsp_valid=0 exactly 3 cycles later. rsp_rgb and rsp_id hold their last values while rsp_valid=0.
- Simultaneous events:
  - All req high: grants rotate 0,1,...,NUM_REQ-1,0.
  - Single req high: that requester is granted every cycle.
  - A requester that drops req between cycles is skipped without penalty.
- rsp_transparent is computed for every valid result, independent of pal_rgb.

Decomposition:
- Package sprite_pkg holds:
  - SPR_ADDR_W, PAL_IDX_W=4, RGB_W=12.
  - typedef rgb12_t packed {r,g,b} 4 bits each.
  - typedef pix_req_t {valid, id, addr}.
- Sub-module rr_arbiter (NUM_REQ): req, pointer -> gnt, gnt_id, any_gnt; combinational.
- Pointer register and pipeline stay in the top.

Test Plan:
- Only req[2]=1 at addr 0x005, ROM model returns index 3, palette returns 12'hFE8 -> gnt=4'b0100 that cycle; 3 cycles later rsp_valid=1, rsp_id=2, rsp_rgb=FE8, rsp_transparent=0.
- req=4'b1111 held 6 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010; rsp_id 0,1,2,3,0,1 starting 3 cycles later.
- req=4'b1010, last grant 3 -> next gnt=0010 (wrap), then 1000, alternating.
- ROM returns index 0, palette D07 -> rsp_rgb=D07, rsp_transparent=1.
- req pattern 1,0,1 on requester 0 -> rsp_valid pattern 1,0,1 shifted 3 cycles; rsp_rgb holds during the bubble.
- Reset_n low for 1 cycle with 3 results in flight -> outputs 0 immediately, no rsp_valid after release; first grant with req=4'b1111 goes to requester 0.

Source files
------------

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Purpose  : Shared widths and types for the sprite pixel arbiter slice.
//             Sprite ROM address width, palette index width, RGB width,
//             packed 4:4:4 colour type and a pixel-request bundle.
//  Revision : 1.0  initial release
// ============================================================================
package sprite_pkg;

  localparam int SPR_ADDR_W = 10;  // 32x32 sprite
  localparam int PAL_IDX_W  = 4;   // 16-entry palette
  localparam int RGB_W      = 12;  // 4 bits per channel
  localparam int MAX_ID_W   = 3;   // up to 8 requesters

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ID_W-1:0]   id;
    logic [SPR_ADDR_W-1:0] addr;
  } pix_req_t;

endpackage
`default_nettype wire

// File: rtl/sprite_pixel_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Searches req starting one
//             position after ptr (modulo NUM_REQ); the first set bit wins.
//  Ports    : req     - per-requester request
//             ptr     - index of the last granted requester
//             gnt     - one-hot grant (zero when no request)
//             gnt_id  - binary index of the winner
//             any_gnt - a grant was issued
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_gnt
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    idx     = 0;
    // Offsets 1..NUM_REQ: the last winner is examined last, giving it the
    // lowest priority this cycle.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        any_gnt  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_pixel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pixel_arbiter
//  Purpose  : Shares one synchronous sprite ROM and one palette among
//             NUM_REQ sprite engines. Round-robin grant, three-stage
//             pipeline, tagged 12-bit RGB result with chroma-key flag.
//  Ports    : Clk, Reset_n (async active-low)
//             req/req_addr         - requests and packed per-requester addrs
//             gnt                  - combinational one-hot grant
//             rom_addr/rom_index   - ROM port (data one cycle after address)
//             pal_index/pal_rgb    - palette port (combinational)
//             rsp_valid/rsp_id/rsp_rgb/rsp_transparent - result, 3 cycles
//                                    after the grant
//  Revision : 1.0  initial release
// ============================================================================
module sprite_pixel_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = SPR_ADDR_W,
  parameter int KEY_INDEX = 0,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [PAL_IDX_W-1:0]      rom_index,
  output logic [PAL_IDX_W-1:0]      pal_index,
  input  logic [RGB_W-1:0]          pal_rgb,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RGB_W-1:0]          rsp_rgb,
  output logic                      rsp_transparent
);

  logic [ID_W-1:0]   gnt_id;
  logic              any_gnt;

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              s2_valid_q;
  logic [ID_W-1:0]   s2_id_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  rgb12_t            rsp_rgb_q, rsp_rgb_d;
  logic              rsp_transparent_q, rsp_transparent_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_gnt (any_gnt)
  );

  always_comb begin
    ptr_d             = ptr_q;
    rom_addr_d        = rom_addr_q;
    s1_valid_d        = any_gnt;
    s1_id_d           = gnt_id;
    rsp_valid_d       = s2_valid_q;
    rsp_id_d          = rsp_id_q;
    rsp_rgb_d         = rsp_rgb_q;
    rsp_transparent_d = rsp_transparent_q;

    if (any_gnt) begin
      ptr_d      = gnt_id;
      rom_addr_d = req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
    end

    // Result fields only move on a valid result so they hold across bubbles.
    if (s2_valid_q) begin
      rsp_id_d          = s2_id_q;
      rsp_rgb_d         = rgb12_t'(pal_rgb);
      rsp_transparent_d = (rom_index == PAL_IDX_W'(KEY_INDEX));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q             <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
      rom_addr_q        <= '0;
      s1_valid_q        <= 1'b0;
      s1_id_q           <= '0;
      s2_valid_q        <= 1'b0;
      s2_id_q           <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_id_q          <= '0;
      rsp_rgb_q         <= '0;
      rsp_transparent_q <= 1'b0;
    end else begin
      ptr_q             <= ptr_d;
      rom_addr_q        <= rom_addr_d;
      s1_valid_q        <= s1_valid_d;
      s1_id_q           <= s1_id_d;
      s2_valid_q        <= s1_valid_q;
      s2_id_q           <= s1_id_q;
      rsp_valid_q       <= rsp_valid_d;
      rsp_id_q          <= rsp_id_d;
      rsp_rgb_q         <= rsp_rgb_d;
      rsp_transparent_q <= rsp_transparent_d;
    end
  end

  assign rom_addr        = rom_addr_q;
  assign pal_index       = rom_index;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_rgb         = rsp_rgb_q;
  assign rsp_transparent = rsp_transparent_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_pixel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_pixel_arbiter
//  Purpose  : Scoreboard bench for sprite_pixel_arbiter with a ROM and
//             palette model, directed scenarios and random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_pixel_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int IW = 2;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [3:0]      rom_index = '0;
  logic [3:0]      pal_index;
  logic [11:0]     pal_rgb;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [11:0]     rsp_rgb;
  logic            rsp_transparent;

  sprite_pixel_arbiter #(
    .NUM_REQ   (N),
    .ADDR_W    (AW),
    .KEY_INDEX (0)
  ) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .req             (req),
    .req_addr        (req_addr),
    .gnt             (gnt),
    .rom_addr        (rom_addr),
    .rom_index       (rom_index),
    .pal_index       (pal_index),
    .pal_rgb         (pal_rgb),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_rgb         (rsp_rgb),
    .rsp_transparent (rsp_transparent)
  );

  always #5 Clk = ~Clk;

  // Memory models: synchronous ROM, combinational palette.
  logic [3:0]  rom_mem [1024];
  logic [11:0] pal_mem [16];
  always @(posedge Clk) rom_index <= rom_mem[rom_addr];
  assign pal_rgb = pal_mem[pal_index];

  typedef struct {
    int          due;
    int          id;
    logic [11:0] rgb;
    logic        tr;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          model_ptr = N - 1;
  logic [11:0] last_rgb = '0;
  int          last_id = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Issue one cycle of requests, check the grant against the model and
  // queue the expected result.
  task automatic drive(input logic [N-1:0] r, input logic [N*AW-1:0] a);
    int          win;
    logic [N-1:0] exp_gnt;
    logic [AW-1:0] ad;
    @(posedge Clk);
    #1;
    req = r;
    req_addr = a;
    #1;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      if (win < 0 && r[(model_ptr + k) % N]) win = (model_ptr + k) % N;
    end
    exp_gnt = '0;
    if (win >= 0) exp_gnt[win] = 1'b1;
    checks++;
    if (gnt !== exp_gnt) begin
      errors++;
      $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt);
    end
    if (win >= 0) begin
      exp_t e;
      ad = a[win*AW +: AW];
      e.due = cyc + 3;
      e.id  = win;
      e.rgb = pal_mem[rom_mem[ad]];
      e.tr  = (rom_mem[ad] == 4'd0);
      q.push_back(e);
      model_ptr = win;
    end
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    req = '0;
    q.delete();
    model_ptr = N - 1;
    last_rgb = '0;
    last_id = 0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  function automatic logic [N*AW-1:0] rand_addrs();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom_range(0, 1023));
    return a;
  endfunction

  // Monitor: compares each cycle's result against the scoreboard head.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      checks++;
      if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_rgb !== '0 ||
          rsp_transparent !== 1'b0 || rom_addr !== '0) begin
        errors++;
        $display("FAIL reset_outputs got v=%b id=%0d rgb=%h t=%b a=%h exp all 0",
                 rsp_valid, rsp_id, rsp_rgb, rsp_transparent, rom_addr);
      end
    end else begin
      logic exp_v;
      while (q.size() > 0 && q[0].due < cyc) begin
        exp_t s;
        s = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_result due=%0d id=%0d", s.due, s.id);
      end
      exp_v = (q.size() > 0 && q[0].due == cyc);
      checks++;
      if (rsp_valid !== exp_v) begin
        errors++;
        $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_v);
      end
      if (exp_v) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (rsp_id !== IW'(e.id) || rsp_rgb !== e.rgb || rsp_transparent !== e.tr) begin
          errors++;
          $display("FAIL rsp_data cyc=%0d got id=%0d rgb=%h t=%b exp id=%0d rgb=%h t=%b",
                   cyc, rsp_id, rsp_rgb, rsp_transparent, e.id, e.rgb, e.tr);
        end
        last_rgb = e.rgb;
        last_id  = e.id;
      end else begin
        checks++;
        if (rsp_rgb !== last_rgb || rsp_id !== IW'(last_id)) begin
          errors++;
          $display("FAIL rsp_hold cyc=%0d got id=%0d rgb=%h exp id=%0d rgb=%h",
                   cyc, rsp_id, rsp_rgb, last_id, last_rgb);
        end
      end
    end
  end

  initial begin
    logic [N*AW-1:0] a;
    for (int i = 0; i < 1024; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    for (int i = 0; i < 16; i++) pal_mem[i] = 12'($urandom);
    rom_mem[10'h005] = 4'd3;
    pal_mem[3]       = 12'hFE8;
    rom_mem[10'h010] = 4'd0;
    pal_mem[0]       = 12'hD07;

    do_reset();

    // Single requester 2 at address 0x005.
    a = rand_addrs();
    a[2*AW +: AW] = 10'h005;
    drive(4'b0100, a);
    for (int i = 0; i < 4; i++) drive('0, rand_addrs());

    // All requesting: rotation 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++) drive(4'b1111, rand_addrs());

    // Set last grant to 3, then alternate 1 and 3 with wrap.
    drive(4'b1000, rand_addrs());
    for (int i = 0; i < 4; i++) drive(4'b1010, rand_addrs());

    // Transparent pixel from requester 0 at 0x010.
    a = rand_addrs();
    a[0 +: AW] = 10'h010;
    drive(4'b0001, a);

    // Pattern 1,0,1 on requester 0 with a bubble.
    drive(4'b0001, rand_addrs());
    drive(4'b0000, rand_addrs());
    drive(4'b0001, rand_addrs());
    for (int i = 0; i < 4; i++) drive('0, rand_addrs());

    // Three results in flight, then reset; afterwards requester 0 first.
    for (int i = 0; i < 3; i++) drive(4'b1111, rand_addrs());
    do_reset();
    for (int i = 0; i < 4; i++) drive(4'b1111, rand_addrs());

    // Random traffic.
    for (int i = 0; i < 300; i++) drive(N'($urandom_range(0, 15)), rand_addrs());

    for (int i = 0; i < 6; i++) drive('0, rand_addrs());
    @(posedge Clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
